// File: rtl/sha256_iter_core.sv
// sha256_iter_core
// Iterative SHA-256 compression engine. Each clock in RUN applies RPC chained
// rounds to the registered working state. One 512-bit block takes 64/RPC
// clocks, then one FEED clock adds the working state into the chain registers.
// The message schedule is expanded on the fly from a 16-word sliding window.
// The chain registers carry the hash state from block to block within a message.
//
// Parameters:
//   RPC        rounds per clock: 1, 2, 4, 8 or 16
//
// Ports:
//   clk        clock; all logic is rising-edge
//   rst        synchronous active-high reset
//   in_valid   a block is present on in_block
//   in_ready   core is idle and can accept a block
//   in_block   message block, W0 in [511:480], big-endian words
//   in_first   1 = start a new message from the IV, 0 = chain from the last digest
//   in_mode224 (SHA256_ITER_SHA224_EN only) SHA-224 mode, sampled with in_first=1
//   out_valid  digest valid
//   out_ready  consumer takes the digest
//   out_digest H0 in [255:224] ... H7 in [31:0]
//   busy       high while rounds or the feed-forward are in progress
//
// Optional feature macro: SHA256_ITER_SHA224_EN
//   Defining it adds in_mode224. In SHA-224 mode the core loads the SHA-224 IV
//   and drives out_digest[31:0] to zero. The internal H7 still chains.
module sha256_iter_core #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
`ifdef SHA256_ITER_SHA224_EN
  input  logic         in_mode224,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  generate
    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8 && RPC != 16) begin : g_rpc_illegal
      $error("sha256_iter_core: RPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [5:0] RPC_INC = 6'(RPC);

  localparam logic [0:7][31:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [0:7][31:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FEED, S_DONE} state_t;

  state_t state_q, state_d;

  logic [5:0]         cnt_q;
  logic               mode_q;
  logic               mode_in;
  logic [0:7][31:0]   h_q;
  logic [0:7][31:0]   wk_q;
  logic [0:15][31:0]  win_q;

  logic [0:15][31:0]  win_d;
  logic [0:7][31:0]   chain_src;
  logic [0:7][31:0]   h_sum;
  logic [0:7][31:0]   dig_d;
  logic [31:0]        ext [16+RPC];
  logic [0:7][31:0]   rs  [RPC+1];
  logic [31:0]        t1, t2;
  logic               accept;

`ifdef SHA256_ITER_SHA224_EN
  assign mode_in = in_mode224;
`else
  assign mode_in = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && in_valid;

  // A new message restarts from the IV of the requested mode; otherwise continue
  // from the digest left in the chain registers.
  always_comb begin
    chain_src = h_q;
    if (in_first) chain_src = mode_in ? IV224 : IV256;
  end

  // Schedule extension and RPC chained rounds. ext[0..15] is the window,
  // ext[16..] are the words the next RPC rounds and the next window need.
  always_comb begin
    ext   = '{default: '0};
    rs    = '{default: '0};
    win_d = '0;
    t1    = '0;
    t2    = '0;
    for (int i = 0; i < 16; i++) ext[i] = win_q[i];
    for (int j = 0; j < RPC; j++)
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    rs[0] = wk_q;
    for (int r = 0; r < RPC; r++) begin
      t1 = rs[r][7] + bsig1(rs[r][4]) + ch(rs[r][4], rs[r][5], rs[r][6])
         + K_TAB[cnt_q + 6'(r)] + ext[r];
      t2 = bsig0(rs[r][0]) + maj(rs[r][0], rs[r][1], rs[r][2]);
      rs[r+1] = {t1 + t2, rs[r][0], rs[r][1], rs[r][2],
                 rs[r][3] + t1, rs[r][4], rs[r][5], rs[r][6]};
    end
    for (int i = 0; i < 16; i++) win_d[i] = ext[RPC+i];
  end

  // Feed-forward. SHA-224 hides H7 on the output but keeps it for chaining.
  always_comb begin
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + wk_q[i];
    dig_d = h_sum;
    if (mode_q) dig_d[7] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // The 6-bit counter wraps to zero after the final round group.
        if (cnt_q + RPC_INC == 6'd0) state_d = S_FEED;
      end
      S_FEED: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural state: counter, mode, chain registers, digest.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      h_q        <= IV256;
      out_digest <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (in_first) begin
              h_q    <= chain_src;
              mode_q <= mode_in;
            end
          end
        end
        S_RUN:  cnt_q <= cnt_q + RPC_INC;
        S_FEED: begin
          h_q        <= h_sum;
          out_digest <= dig_d;
        end
        default: ;
      endcase
    end
  end

  // Working variables and schedule window. These are pure data and are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= in_block;
      wk_q  <= chain_src;
    end else if (state_q == S_RUN) begin
      win_q <= win_d;
      wk_q  <= rs[RPC];
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
module tb_sha256_iter_core;

  localparam int NCH = 3;

  function automatic int rpc_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [NCH];
  logic         in_valid  [NCH];
  logic         in_ready  [NCH];
  logic [511:0] in_block  [NCH];
  logic         in_first  [NCH];
  logic         out_valid [NCH];
  logic         out_ready [NCH];
  logic [255:0] out_digest[NCH];
  logic         busy      [NCH];
`ifdef SHA256_ITER_SHA224_EN
  logic         in_mode224[NCH];
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_dut
    sha256_iter_core #(.RPC(rpc_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_block  (in_block[g]),
      .in_first  (in_first[g]),
`ifdef SHA256_ITER_SHA224_EN
      .in_mode224(in_mode224[g]),
`endif
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_digest(out_digest[g]),
      .busy      (busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  kt [64];
  logic [255:0] iv256, iv224;
  logic [255:0] chain  [NCH];
  logic         mode_m [NCH];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Integer k-th root by bit-wise search: floor(n^(1/k)).
  function automatic logic [159:0] iroot(input logic [159:0] n, input int k, input int bits);
    logic [159:0] r, c, p;
    r = '0;
    for (int b = bits - 1; b >= 0; b--) begin
      c = r | (160'd1 << b);
      p = (k == 2) ? c * c : c * c * c;
      if (p <= n) r = c;
    end
    return r;
  endfunction

  // Constants from first principles: fractional bits of square and cube roots of primes.
  task automatic build_tables();
    int primes[64];
    int cnt;
    logic [159:0] r;
    bit isp;
    cnt = 0;
    for (int x = 2; cnt < 64; x++) begin
      isp = 1'b1;
      for (int d = 2; d * d <= x; d++) if (x % d == 0) isp = 1'b0;
      if (isp) begin
        primes[cnt] = x;
        cnt++;
      end
    end
    for (int t = 0; t < 64; t++) begin
      r = iroot(160'(primes[t]) << 96, 3, 36);
      kt[t] = r[31:0];
    end
    for (int i = 0; i < 8; i++) begin
      r = iroot(160'(primes[i]) << 64, 2, 36);
      iv256[255-32*i -: 32] = r[31:0];
      r = iroot(160'(primes[8+i]) << 128, 2, 68);
      iv224[255-32*i -: 32] = r[31:0];
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-block reference: full 64-entry schedule, then 64 rounds, then feed-forward.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      x1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + kt[t] + w[t];
      x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1;
      d = c; c = b; b = a; a = x1 + x2;
    end
    res = {a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++)
      res[255-32*i -: 32] = res[255-32*i -: 32] + hin[255-32*i -: 32];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Advance the per-channel model by one accepted block; returns the visible digest.
  function automatic logic [255:0] model_step(input int k, input logic [511:0] blk,
                                              input logic first, input logic m224);
    if (first) begin
      chain[k]  = m224 ? iv224 : iv256;
      mode_m[k] = m224;
    end
    chain[k] = ref_compress(chain[k], blk);
    return mode_m[k] ? {chain[k][255:32], 32'h0} : chain[k];
  endfunction

  task automatic drive_in(input int k, input logic v, input logic [511:0] blk,
                          input logic first, input logic m224);
    in_valid[k] = v;
    in_block[k] = blk;
    in_first[k] = first;
`ifdef SHA256_ITER_SHA224_EN
    in_mode224[k] = m224;
`else
    if (m224) $fatal(1, "FAIL mode224 requested without SHA256_ITER_SHA224_EN");
`endif
  endtask

  // Send one block, check latency and digest, then take the digest.
  task automatic run_block(input int k, input logic [511:0] blk, input logic first,
                           input logic m224, input string tag, output logic [255:0] dig);
    logic [255:0] exp;
    int n;
    chk({tag, " in_ready_idle"}, 256'(in_ready[k]), 256'(1));
    drive_in(k, 1'b1, blk, first, m224);
    exp = model_step(k, blk, first, m224);
    tick();
    drive_in(k, 1'b0, rand_block(), $urandom_range(0, 1), 1'b0);
    chk({tag, " busy_run"}, {254'(0), busy[k], in_ready[k]}, 256'(2));
    n = 1;
    while (out_valid[k] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 256'(n), 256'(64 / rpc_of(k) + 2));
    chk({tag, " digest"}, out_digest[k], exp);
    dig = out_digest[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
    chk({tag, " release"}, {254'(0), out_valid[k], in_ready[k]}, 256'(1));
  endtask

  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO_A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO_B = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  initial begin
    logic [255:0] dig, exp, held;
    logic [511:0] blk;
    int n, rises, t0, t1, nb;

    build_tables();
    for (int k = 0; k < NCH; k++) begin
      rst[k] = 1'b1;
      out_ready[k] = 1'b0;
      drive_in(k, 1'b0, '0, 1'b0, 1'b0);
      chain[k] = iv256;
      mode_m[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < NCH; k++) rst[k] = 1'b0;

    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("reset ctl ch%0d", k),
          {253'(0), in_ready[k], out_valid[k], busy[k]}, 256'(4));
      chk($sformatf("reset digest ch%0d", k), out_digest[k], 256'(0));
    end

    // Known vectors on each rounds-per-clock variant.
    run_block(0, BLK_ABC, 1'b1, 1'b0, "abc_rpc1", dig);
    chk("abc_rpc1 known", dig, DIG_ABC);
    run_block(2, BLK_EMPTY, 1'b1, 1'b0, "empty_rpc4", dig);
    chk("empty_rpc4 known", dig, DIG_EMPTY);
    run_block(1, BLK_TWO_A, 1'b1, 1'b0, "two_blk1_rpc2", dig);
    run_block(1, BLK_TWO_B, 1'b0, 1'b0, "two_blk2_rpc2", dig);
    chk("two_rpc2 known", dig, DIG_TWO);

    // Backpressure: digest held while out_ready is low, in_valid ignored.
    blk = rand_block();
    drive_in(2, 1'b1, blk, 1'b0, 1'b0);
    exp = model_step(2, blk, 1'b0, 1'b0);
    tick();
    drive_in(2, 1'b0, '0, 1'b0, 1'b0);
    n = 1;
    while (out_valid[2] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("bp latency", 256'(n), 256'(18));
    chk("bp digest", out_digest[2], exp);
    held = out_digest[2];
    for (int i = 0; i < 10; i++) begin
      drive_in(2, 1'(i % 2), rand_block(), 1'b1, 1'b0);
      tick();
      chk($sformatf("bp hold ctl %0d", i), {254'(0), out_valid[2], in_ready[2]}, 256'(2));
      chk($sformatf("bp hold digest %0d", i), out_digest[2], held);
    end
    drive_in(2, 1'b0, '0, 1'b0, 1'b0);
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;
    chk("bp release", {253'(0), in_ready[2], out_valid[2], busy[2]}, 256'(4));
    tick();
    tick();
    chk("bp no stray start", {253'(0), in_ready[2], out_valid[2], busy[2]}, 256'(4));
    // Continuing the message proves the held digest, not a pulsed block, was chained.
    run_block(2, rand_block(), 1'b0, 1'b0, "bp chain", dig);

    // Reset in the middle of RUN at counter 24.
    drive_in(0, 1'b1, rand_block(), 1'b1, 1'b0);
    tick();
    drive_in(0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) tick();
    chk("pre_reset busy", 256'(busy[0]), 256'(1));
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chain[0] = iv256;
    mode_m[0] = 1'b0;
    chk("midrst ctl", {253'(0), in_ready[0], out_valid[0], busy[0]}, 256'(4));
    chk("midrst digest", out_digest[0], 256'(0));
    // in_first=0 right after reset must continue from the IV.
    run_block(0, BLK_ABC, 1'b0, 1'b0, "midrst abc_chain_iv", dig);
    chk("midrst abc_chain_iv known", dig, DIG_ABC);
    run_block(0, BLK_ABC, 1'b1, 1'b0, "midrst abc", dig);
    chk("midrst abc known", dig, DIG_ABC);

    // Throughput with out_ready tied high and in_valid held.
    blk = rand_block();
    exp = model_step(2, blk, 1'b1, 1'b0);
    out_ready[2] = 1'b1;
    drive_in(2, 1'b1, blk, 1'b1, 1'b0);
    n = 0; rises = 0; t0 = 0; t1 = 0;
    while (rises < 2 && n < 200) begin
      tick();
      n++;
      if (out_valid[2] === 1'b1) begin
        rises++;
        if (rises == 1) t0 = n;
        else t1 = n;
        chk($sformatf("thr digest %0d", rises), out_digest[2], exp);
      end
    end
    drive_in(2, 1'b0, '0, 1'b0, 1'b0);
    chk("thr period", 256'(t1 - t0), 256'(64 / 4 + 3));
    tick();
    out_ready[2] = 1'b0;
    chk("thr idle", {254'(0), in_ready[2], out_valid[2]}, 256'(2));

    // Randomized messages on every variant against the reference model.
    for (int k = 0; k < NCH; k++) begin
      for (int m = 0; m < 3; m++) begin
        nb = $urandom_range(1, 2);
        for (int b = 0; b < nb; b++)
          run_block(k, rand_block(), (b == 0) && (m != 1), 1'b0,
                    $sformatf("rand ch%0d m%0d b%0d", k, m, b), dig);
      end
    end

`ifdef SHA256_ITER_SHA224_EN
    run_block(1, BLK_ABC, 1'b1, 1'b1, "sha224 abc", dig);
    chk("sha224 abc known", dig,
        {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0});
    run_block(1, rand_block(), 1'b0, 1'b0, "sha224 chain", dig);
    run_block(1, BLK_ABC, 1'b1, 1'b0, "sha224 back_to_256", dig);
    chk("sha224 back_to_256 known", dig, DIG_ABC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
